// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier using an external N-bit adder.
// Optional build macro EARLY_TERM_EN: a zero operand skips the RUN phase entirely.
module shift_add_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] P,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout
);

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    q_q, q_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            zero_operand;

`ifdef EARLY_TERM_EN
  assign zero_operand = (A == '0) || (B == '0);
`else
  assign zero_operand = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d   = A;
          acc_d = '0;
          cnt_d = '0;
          if (zero_operand) begin
            q_d     = '0;
            state_d = StDone;
          end else begin
            q_d     = B;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Adder carry lands in the ACC MSB, so the 2N-bit product cannot overflow.
        {acc_d, q_d} = {add_cout, add_sum, q_q[N-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready   = (state_q == StIdle);
  assign done    = (state_q == StDone);
  assign P       = {acc_q, q_q};
  assign add_a   = acc_q;
  assign add_b   = q_q[0] ? m_q : '0;
  assign add_cin = 1'b0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (N=4) with a behavioural ripple adder.
// Expected products and done latency are queued on each accepted start.
module tb_shift_add_multiplier;

  localparam int unsigned N = 4;

`ifdef EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic           clk;
  logic           n_reset;
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           ready;
  logic           done;
  logic [2*N-1:0] P;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  typedef struct {
    logic [2*N-1:0] prod;
    int             accept_cyc;
    int             lat;
  } exp_t;

  exp_t           sb[$];
  int             cyc;
  int             checks;
  int             errors;
  logic [2*N-1:0] held_p;
  bit             held_valid;

  shift_add_multiplier #(.N(N)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .ready    (ready),
    .done     (done),
    .P        (P),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sampled on the falling edge, well away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!n_reset) begin
      held_valid = 1'b0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("product", 32'(P), 32'(e.prod));
          check_eq("latency", 32'(cyc - e.accept_cyc), 32'(e.lat));
          held_p     = e.prod;
          held_valid = 1'b1;
        end
      end else if (ready && held_valid) begin
        check_eq("held_p", 32'(P), 32'(held_p));
      end
      if (ready && start) begin
        e.prod       = (2*N)'(A) * (2*N)'(B);
        e.accept_cyc = cyc;
        e.lat        = (EarlyTerm && (A == 0 || B == 0)) ? 1 : N + 1;
        sb.push_back(e);
        held_valid   = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready) check_eq("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    wait_ready();
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    drain();
    // Idle a couple of cycles so the hold check sees P stable.
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    held_valid = 1'b0;
    n_reset    = 1'b0;
    start      = 1'b0;
    A          = '0;
    B          = '0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_p", 32'(P), 32'h00);

    run_op(4'd3, 4'd5);
    run_op(4'd15, 4'd15);
    run_op(4'd15, 4'd1);
    run_op(4'd1, 4'd15);
    run_op(4'd0, 4'd9);
    run_op(4'd9, 4'd0);
    for (int i = 0; i < 4; i++) begin
      run_op(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    end

    // Start held high: back-to-back products, starts in RUN/DONE must be ignored.
    wait_ready();
    A     = 4'd7;
    B     = 4'd6;
    start = 1'b1;
    repeat (3 * (N + 2)) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Start asserted with other operands while busy must not disturb the product.
    wait_ready();
    A     = 4'd5;
    B     = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 4'd2;
    B = 4'd2;
    repeat (N + 1) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Asynchronous reset in the second RUN cycle of 9*9.
    wait_ready();
    A     = 4'd9;
    B     = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(ready), 32'd1);
    check_eq("midrst_p", 32'(P), 32'h00);
    check_eq("midrst_done", 32'(done), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (N + 3) @(posedge clk);
    #1;
    run_op(4'd2, 4'd3);
    check_eq("post_rst_p", 32'(P), 32'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
